// File: rtl/bias_mem_pkg.sv
// Shared width constants, derived words-per-line and FSM encoding for the bias memory path.
package bias_mem_pkg;

  localparam int unsigned BIAS_CHANNEL_WIDTH = 288;
  localparam int unsigned WR_ADDR_DEPTH      = 9;
  localparam int unsigned IN_WIDTH           = 32;

  localparam int unsigned WPL    = BIAS_CHANNEL_WIDTH / IN_WIDTH;
  localparam int unsigned WCNT_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned LCNT_W = WR_ADDR_DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [WR_ADDR_DEPTH-1:0]      addr;
    logic [BIAS_CHANNEL_WIDTH-1:0] data;
  } bias_wr_t;

endpackage

// File: rtl/bias_word_packer.sv
// Packs accepted stream words LSB-first into a bias line; flags the word that completes a line.
module bias_word_packer
  import bias_mem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          word_en,
  input  logic [IN_WIDTH-1:0]           word,
  output logic                          line_valid_c,
  output logic [BIAS_CHANNEL_WIDTH-1:0] line_c
);

  logic [WCNT_W-1:0]             wcnt_q, wcnt_d;
  logic [BIAS_CHANNEL_WIDTH-1:0] pack_q, pack_d;

  // line_c is the pack register with the incoming word already merged in
  always_comb begin
    line_c       = pack_q;
    pack_d       = pack_q;
    wcnt_d       = wcnt_q;
    line_valid_c = 1'b0;
    for (int unsigned k = 0; k < WPL; k++) begin
      if (wcnt_q == WCNT_W'(k)) begin
        line_c[k*IN_WIDTH +: IN_WIDTH] = word;
      end
    end
    if (word_en) begin
      line_valid_c = (wcnt_q == WCNT_W'(WPL - 1));
      pack_d       = line_c;
      wcnt_d       = line_valid_c ? '0 : wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      pack_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/bias_mem_loader.sv
// Streams bias words into packed lines and writes them to the bias DRM at sequential addresses.
// Optional BIAS_LOADER_CHECKSUM_EN adds a 32-bit sum of accepted words (load_checksum).
module bias_mem_loader
  import bias_mem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [WR_ADDR_DEPTH-1:0]      load_base_addr,
  input  logic [LCNT_W-1:0]             load_num_lines,
  input  logic [IN_WIDTH-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          mem_wr_en,
  output logic [WR_ADDR_DEPTH-1:0]      mem_wr_addr,
  output logic [BIAS_CHANNEL_WIDTH-1:0] mem_wr_data,
  output logic                          load_busy,
  output logic                          load_done
`ifdef BIAS_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]                   load_checksum
`endif
);

  state_e                   state_q, state_d;
  logic [WR_ADDR_DEPTH-1:0] base_q, base_d;
  logic [LCNT_W-1:0]        num_q, num_d;
  logic [LCNT_W-1:0]        idx_q, idx_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     wr_en_q, wr_en_d;
  bias_wr_t                 wr_q, wr_d;

  logic                          word_en;
  logic                          line_valid_c;
  logic [BIAS_CHANNEL_WIDTH-1:0] line_c;

  assign word_en = s_valid && ready_q;

  bias_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .word_en      (word_en),
    .word         (s_data),
    .line_valid_c (line_valid_c),
    .line_c       (line_c)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    wr_d    = wr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          base_d  = load_base_addr;
          num_d   = load_num_lines;
          idx_d   = '0;
          state_d = (load_num_lines == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (line_valid_c) begin
          wr_en_d   = 1'b1;
          wr_d.addr = base_q + idx_q[WR_ADDR_DEPTH-1:0];
          wr_d.data = line_c;
          idx_d     = idx_q + LCNT_W'(1);
          if (idx_q == num_q - LCNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy covers FILL and the final-write cycle, never the completion pulse
    ready_d = (state_d == FILL);
    busy_d  = (state_d != IDLE) && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      wr_q    <= wr_d;
    end
  end

  assign s_ready     = ready_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_q.addr;
  assign mem_wr_data = wr_q.data;

`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && load_start) begin
      csum_d = '0;
    end else if (word_en) begin
      csum_d = csum_q + 32'(s_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign load_checksum = csum_q;
`endif

endmodule

// File: tb/tb_bias_mem_loader.sv
// Self-checking bench for bias_mem_loader: line-level write model plus directed literal checks.
module tb_bias_mem_loader;
  import bias_mem_pkg::*;

  localparam int unsigned DW = BIAS_CHANNEL_WIDTH;
  localparam int unsigned AW = WR_ADDR_DEPTH;
  localparam int unsigned IW = IN_WIDTH;
  localparam int unsigned NW = DW / IW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base_addr = '0;
  logic [AW:0]   load_num_lines = '0;
  logic [IW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          load_busy;
  logic          load_done;
`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [31:0]   load_checksum;
`endif

  always #5 clk = ~clk;

  bias_mem_loader dut (
    .clk            (clk),
    .rst            (rst),
    .load_start     (load_start),
    .load_base_addr (load_base_addr),
    .load_num_lines (load_num_lines),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .load_busy      (load_busy),
    .load_done      (load_done)
`ifdef BIAS_LOADER_CHECKSUM_EN
    ,
    .load_checksum  (load_checksum)
`endif
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_done_cyc = -1;
  int          nlog = 0;
  wr_t         exp_q[$];
  wr_t         log_w[0:15];
  wr_t         e;
  logic [31:0] exp_sum = '0;
  logic [31:0] wbuf[0:63];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: every write must match the next expected line; done comes one cycle after the last write
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("load_done_timing", DW'(load_done), DW'(cyc == exp_done_cyc));
      if (mem_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", DW'(1), DW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", DW'(mem_wr_addr), DW'(e.addr));
          chk("wr_data", mem_wr_data, e.data);
          chk("busy_on_write", DW'(load_busy), DW'(1));
          if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
        end
        if (nlog < 16) begin
          log_w[nlog].addr = mem_wr_addr;
          log_w[nlog].data = mem_wr_data;
          nlog++;
        end
      end
      if (load_done) begin
        chk("busy_at_done", DW'(load_busy), DW'(0));
        chk("ready_at_done", DW'(s_ready), DW'(0));
`ifdef BIAS_LOADER_CHECKSUM_EN
        chk("checksum_model", DW'(load_checksum), DW'(exp_sum));
`endif
      end
    end
  end

  // Pulses load_start and queues the lines the model expects from wbuf
  task automatic start_load(input logic [AW-1:0] base, input int nlines);
    logic [DW-1:0] line;
    wr_t w;
    nlog = 0;
    exp_sum = '0;
    for (int i = 0; i < nlines; i++) begin
      for (int k = 0; k < int'(NW); k++) line[k*IW +: IW] = wbuf[i*int'(NW) + k];
      w.addr = AW'((int'(base) + i) % (1 << AW));
      w.data = line;
      exp_q.push_back(w);
    end
    if (nlines == 0) exp_done_cyc = cyc + 3;
    load_start     = 1'b1;
    load_base_addr = base;
    load_num_lines = (AW + 1)'(nlines);
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_words(input int first, input int n, input bit stall);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < n && guard < 500) begin
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = wbuf[first + i];
      acc     = s_valid && s_ready;
      tick();
      if (acc) begin
        exp_sum = exp_sum + wbuf[first + i];
        i++;
      end
      guard++;
    end
    s_valid = 1'b0;
    chk("send_timeout", DW'(i), DW'(n));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (load_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, DW'(n < 100), DW'(1));
    tick();
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_wr_en", DW'(mem_wr_en), DW'(0));
    chk("rst_ready", DW'(s_ready), DW'(0));
    chk("rst_busy", DW'(load_busy), DW'(0));
    chk("rst_done", DW'(load_done), DW'(0));
    chk("rst_data", mem_wr_data, DW'(0));
    rst = 1'b0;
    tick();

    // basic load: 2 lines from base 0, words 1..18
    for (int i = 0; i < 64; i++) wbuf[i] = 32'(i + 1);
    start_load(AW'(0), 2);
    send_words(0, 18, 1'b0);
    wait_done("basic_done_seen");
    chk("basic_nwr", DW'(nlog), DW'(2));
    chk("basic_addr0", DW'(log_w[0].addr), DW'(0));
    chk("basic_w1", DW'(log_w[0].data[31:0]), DW'(32'h1));
    chk("basic_w9", DW'(log_w[0].data[287:256]), DW'(32'h9));
    chk("basic_addr1", DW'(log_w[1].addr), DW'(1));
    chk("basic_w10", DW'(log_w[1].data[31:0]), DW'(32'hA));
    chk("basic_w18", DW'(log_w[1].data[287:256]), DW'(32'h12));

    // backpressure: same words, random s_valid gaps
    start_load(AW'(0), 2);
    send_words(0, 18, 1'b1);
    wait_done("bp_done_seen");
    chk("bp_nwr", DW'(nlog), DW'(2));

    // address wrap from 511 to 0
    start_load(AW'(511), 2);
    send_words(0, 18, 1'b1);
    wait_done("wrap_done_seen");
    chk("wrap_addr0", DW'(log_w[0].addr), DW'(511));
    chk("wrap_addr1", DW'(log_w[1].addr), DW'(0));

    // zero lines: done two cycles after start, no write
    start_load(AW'(7), 0);
    wait_done("zero_done_seen");
    chk("zero_nwr", DW'(nlog), DW'(0));

    // load_start during FILL is ignored
    for (int i = 0; i < 64; i++) wbuf[i] = 32'h1000 + 32'(i * 3);
    start_load(AW'(20), 1);
    send_words(0, 4, 1'b0);
    load_start     = 1'b1;
    load_base_addr = AW'(100);
    load_num_lines = (AW + 1)'(5);
    tick();
    load_start = 1'b0;
    send_words(4, 5, 1'b0);
    wait_done("ign_done_seen");
    chk("ign_nwr", DW'(nlog), DW'(1));
    chk("ign_addr", DW'(log_w[0].addr), DW'(20));

    // reset after 5 words of line 0
    start_load(AW'(0), 1);
    send_words(0, 5, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    exp_done_cyc = -1;
    tick();
    chk("mid_rst_wr_en", DW'(mem_wr_en), DW'(0));
    chk("mid_rst_ready", DW'(s_ready), DW'(0));
    chk("mid_rst_busy", DW'(load_busy), DW'(0));
    chk("mid_rst_done", DW'(load_done), DW'(0));
    chk("mid_rst_addr", DW'(mem_wr_addr), DW'(0));
    chk("mid_rst_data", mem_wr_data, DW'(0));
    rst = 1'b0;
    nlog = 0;
    repeat (10) tick();
    chk("mid_rst_no_wr", DW'(nlog), DW'(0));
    for (int i = 0; i < 64; i++) wbuf[i] = 32'hA000 + 32'(i);
    start_load(AW'(3), 1);
    send_words(0, 9, 1'b0);
    wait_done("post_rst_done_seen");
    chk("post_rst_addr", DW'(log_w[0].addr), DW'(3));
    chk("post_rst_w0", DW'(log_w[0].data[31:0]), DW'(32'hA000));

`ifdef BIAS_LOADER_CHECKSUM_EN
    for (int i = 0; i < 64; i++) wbuf[i] = 32'hFFFF_FFFF;
    start_load(AW'(0), 1);
    send_words(0, 9, 1'b0);
    wait_done("csum_done_seen");
    chk("csum_literal", DW'(load_checksum), DW'(32'hFFFF_FFF7));
`endif

    repeat (5) tick();
    chk("final_queue_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bias_mem_loader.md
Name: bias_mem_loader

Overview:
- Write-side counterpart of the bias memory read path.
- Accepts a narrow valid/ready stream of bias words and packs consecutive words into BIAS_CHANNEL_WIDTH-bit lines.
- Writes each completed line into the bias DRM at sequential addresses.
- Runs once per layer load, before the compute FSM starts issuing read addresses.

Parameters:
- BIAS_CHANNEL_WIDTH, 288: width of one bias memory line.
- WR_ADDR_DEPTH, 9: bias memory address width.
- IN_WIDTH, 32: stream word width; BIAS_CHANNEL_WIDTH must be an integer multiple of it.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active high
- load_start  in  1  one-cycle pulse that begins a load
- load_base_addr  in  WR_ADDR_DEPTH  first line address, sampled on load_start
- load_num_lines  in  WR_ADDR_DEPTH+1  number of lines to write, sampled on load_start
- s_data  in  IN_WIDTH  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- mem_wr_en  out  1  bias memory write strobe
- mem_wr_addr  out  WR_ADDR_DEPTH  write address
- mem_wr_data  out  BIAS_CHANNEL_WIDTH  packed line
- load_busy  out  1  high from the cycle after an accepted load_start until done
- load_done  out  1  one-cycle completion pulse

Behaviour:
- Derived constant: WPL = BIAS_CHANNEL_WIDTH/IN_WIDTH (9 at defaults).
- Reset: all outputs 0, FSM in IDLE, word counter 0, line counter 0, pack register 0. Reset mid-load aborts immediately: no further writes and no load_done.
- IDLE:
  - s_ready = 0.
  - load_start latches base address and line count.
  - Count 0: go to DONE.
  - Otherwise: go to FILL.
  - load_start while not in IDLE is ignored.
- FILL:
  - s_ready = 1; a word is accepted when s_valid && s_ready.
  - Accepted word k of a line is placed at bits [k*IN_WIDTH +: IN_WIDTH], LSB word first.
  - On accepting word WPL-1: the complete line, including that word, is copied to mem_wr_data; mem_wr_en = 1 in the next cycle; the word counter clears.
  - No bubble between lines: s_ready stays 1, so the first word of the next line may be accepted in the same cycle mem_wr_en is high.
  - The pack register and the write register are separate.
- Write addressing:
  - mem_wr_addr = base + line index, modulo 2^WR_ADDR_DEPTH. Wrap from all-ones to 0 is legal and silent.
  - mem_wr_en is high for exactly one cycle per line; mem_wr_data and mem_wr_addr are stable in that cycle.
- End of load:
  - When the final line's word WPL-1 is accepted, s_ready drops in the following cycle (the final-write cycle) and the FSM enters DONE.
  - DONE lasts one cycle: load_done = 1, load_busy = 0, then back to IDLE.
  - For a normal load, load_done is asserted the cycle after the final mem_wr_en.
- Stream stalls: s_valid low for any duration holds all state; there is no timeout.
- Words presented while s_ready = 0 are not consumed.
- load_busy = 1 in FILL and during the final-write cycle.

Optional Feature:
- Macro: BIAS_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output load_checksum (32 bits): the modulo-2^32 sum of all accepted s_data words, each zero-extended to 32 bits.
  - Cleared on accepted load_start and on rst.
  - Valid and held from the load_done cycle until the next accepted load_start.
- When undefined: the port and the accumulator do not exist; all other behaviour is identical.

Decomposition:
- Shared package bias_mem_pkg holds:
  - width defaults: BIAS_CHANNEL_WIDTH, WR_ADDR_DEPTH, IN_WIDTH;
  - derived WPL;
  - FSM state encoding: IDLE = 0, FILL = 1, DONE = 2.
- The read-side blocks import the same width constants.
- One natural sub-module, bias_word_packer: word counter plus pack register, emitting a line_valid pulse and the packed line.
- FSM and address generation stay in bias_mem_loader.

Test Plan:
- Basic load: load_start, base 0, 2 lines; 18 words 0x00000001..0x00000012 with s_valid held high. Required: mem_wr_en at addr 0 with word 1 in bits [31:0] and word 9 in bits [287:256]; then addr 1 with words 10..18; load_done one cycle after the second write.
- Backpressure: the same 18 words with s_valid toggling 1-0-0-1 randomly. Required: identical write data and addresses; no extra writes.
- Address wrap: base 511, 2 lines. Required: writes to addr 511, then addr 0.
- Zero lines and ignored start: count 0 gives load_done two cycles after load_start with no mem_wr_en. A second load_start during FILL is ignored, and the line count is unchanged.
- Reset mid-load: rst asserted after 5 words of line 0. Required: all outputs 0 the next cycle; no write and no load_done follow. A new load then starts cleanly from word 0.
- Checksum (macro defined): 9 words, each 0xFFFFFFFF. Required: load_checksum = 0xFFFFFFF7 at load_done.
